pet_estado_fsm: RTL and testbench

Pet mood/condition state machine for the virtual-pet design. Consumes the four 2-bit need levels (ánimo, energía, descanso, medicina) and the 5-second tick produced by the mode block, and decides the pet's displayed state. It closes the loop by driving the feed and medicine enables back into that block. It also implements the test-mode manual state stepping used by the display team.

---
 rtl/pet_pkg.sv | 40 ++++
 rtl/pet_candidato.sv | 46 ++++
 rtl/pet_estado_fsm.sv | 170 +++++++++++++++++
 tb/tb_pet_estado_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// -----------------------------------------------------------------------------
// pet_pkg
// Shared definitions for the virtual-pet state logic and the display decoder.
//   - 3-bit state codes (FELIZ..MUERTO) plus the unused code 7
//   - level scale constants (NIVEL_VACIO / NIVEL_LLENO)
//   - default hysteresis and death-timeout parameters
//   - paso_test(): the manual step order used in test mode
// -----------------------------------------------------------------------------
package pet_pkg;

  localparam int ESTADO_W = 3;
  localparam int NIVEL_W  = 2;

  localparam logic [ESTADO_W-1:0] FELIZ      = 3'd0;
  localparam logic [ESTADO_W-1:0] NEUTRAL    = 3'd1;
  localparam logic [ESTADO_W-1:0] HAMBRIENTO = 3'd2;
  localparam logic [ESTADO_W-1:0] CANSADO    = 3'd3;
  localparam logic [ESTADO_W-1:0] TRISTE     = 3'd4;
  localparam logic [ESTADO_W-1:0] ENFERMO    = 3'd5;
  localparam logic [ESTADO_W-1:0] MUERTO     = 3'd6;
  // Never produced by the evaluator; also used as the "no previous candidate"
  // marker so the first evaluated edge always restarts the stability count.
  localparam logic [ESTADO_W-1:0] ESTADO_INV = 3'd7;

  localparam logic [NIVEL_W-1:0] NIVEL_VACIO = 2'd0;
  localparam logic [NIVEL_W-1:0] NIVEL_LLENO = 2'd3;

  localparam int STABLE_CYCLES_DEF = 4;
  localparam int MUERTE_TICKS_DEF  = 6;

  // Test-mode stepping: FELIZ -> NEUTRAL -> ... -> ENFERMO -> FELIZ.
  // MUERTO is never reached by stepping.
  function automatic logic [ESTADO_W-1:0] paso_test(input logic [ESTADO_W-1:0] e);
    logic [ESTADO_W-1:0] r;
    if (e >= ENFERMO) r = FELIZ;
    else              r = e + 3'd1;
    return r;
  endfunction

endpackage

// File: rtl/pet_candidato.sv
// -----------------------------------------------------------------------------
// pet_candidato
// Purely combinational priority evaluator of the pet's candidate state.
// Ports:
//   nivel_animo/energia/descanso/medicina  in  2-bit need levels (3 = full)
//   candidato                              out 3-bit candidate state code
//   dos_vacios                             out two or more levels are empty
// Priority: medicina empty > energia empty > descanso empty > animo empty >
//           all levels >= 2 (FELIZ) > NEUTRAL.
// -----------------------------------------------------------------------------
module pet_candidato
  import pet_pkg::*;
(
  input  logic [NIVEL_W-1:0]  nivel_animo,
  input  logic [NIVEL_W-1:0]  nivel_energia,
  input  logic [NIVEL_W-1:0]  nivel_descanso,
  input  logic [NIVEL_W-1:0]  nivel_medicina,
  output logic [ESTADO_W-1:0] candidato,
  output logic                dos_vacios
);

  logic vacio_a;
  logic vacio_e;
  logic vacio_d;
  logic vacio_m;
  logic [2:0] n_vacios;

  always_comb begin
    vacio_a = (nivel_animo    == NIVEL_VACIO);
    vacio_e = (nivel_energia  == NIVEL_VACIO);
    vacio_d = (nivel_descanso == NIVEL_VACIO);
    vacio_m = (nivel_medicina == NIVEL_VACIO);

    n_vacios = {2'b00, vacio_a} + {2'b00, vacio_e} + {2'b00, vacio_d} + {2'b00, vacio_m};
    dos_vacios = (n_vacios >= 3'd2);

    candidato = NEUTRAL;
    if (vacio_m)      candidato = ENFERMO;
    else if (vacio_e) candidato = HAMBRIENTO;
    else if (vacio_d) candidato = CANSADO;
    else if (vacio_a) candidato = TRISTE;
    else if (nivel_animo[1] && nivel_energia[1] && nivel_descanso[1] && nivel_medicina[1])
      candidato = FELIZ;  // bit 1 set means level >= 2
  end

endmodule

// File: rtl/pet_estado_fsm.sv
// -----------------------------------------------------------------------------
// pet_estado_fsm
// Pet mood/condition state machine: hysteresis-filtered state selection from
// the four need levels, a death timeout driven by the 5 s tick, registered
// feed/medicine enables, and manual state stepping in test mode.
// Parameters:
//   STABLE_CYCLES  consecutive edges a new candidate must persist (1..8)
//   MUERTE_TICKS   consecutive qualifying ticks before MUERTO
// Ports:
//   clk, reset (async, active-high)
//   nivel_animo/energia/descanso/medicina  2-bit need levels
//   tick_5seg        one-cycle pulse every 5 s
//   senal_test       test mode level
//   boton_test       one-cycle step pulse (test mode only)
//   estado           current state code (also the FSM state for observation)
//   cambio_estado    one-cycle pulse coincident with every new estado value
//   activo_comida    feeding enabled (energia not full and pet alive)
//   activo_medicina  medicine enabled (estado was ENFERMO)
//   muerto           sticky death flag
// Handshake note: there is no valid/ready traffic here; tick_5seg and
// boton_test are single-cycle strobes consumed on the edge that samples them.
// -----------------------------------------------------------------------------
module pet_estado_fsm
  import pet_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int MUERTE_TICKS  = MUERTE_TICKS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NIVEL_W-1:0]  nivel_animo,
  input  logic [NIVEL_W-1:0]  nivel_energia,
  input  logic [NIVEL_W-1:0]  nivel_descanso,
  input  logic [NIVEL_W-1:0]  nivel_medicina,
  input  logic                tick_5seg,
  input  logic                senal_test,
  input  logic                boton_test,
  output logic [ESTADO_W-1:0] estado,
  output logic                cambio_estado,
  output logic                activo_comida,
  output logic                activo_medicina,
  output logic                muerto
);

  localparam int MW = $clog2(MUERTE_TICKS + 1);
  localparam logic [2:0]    STABLE_LIM = 3'(STABLE_CYCLES - 1);
  localparam logic [MW-1:0] MUERTE_LIM = MW'(MUERTE_TICKS);

  // Candidate evaluation
  logic [ESTADO_W-1:0] candidato;
  logic                dos_vacios;

  pet_candidato u_candidato (
    .nivel_animo    (nivel_animo),
    .nivel_energia  (nivel_energia),
    .nivel_descanso (nivel_descanso),
    .nivel_medicina (nivel_medicina),
    .candidato      (candidato),
    .dos_vacios     (dos_vacios)
  );

  // State and counters
  logic [ESTADO_W-1:0] estado_q,    estado_d;
  logic [ESTADO_W-1:0] cand_prev_q, cand_prev_d;
  logic [2:0]          estab_q,     estab_d;
  logic [MW-1:0]       muerte_q,    muerte_d;

  // Registered outputs
  logic cambio_q,          cambio_d;
  logic activo_comida_q,   activo_comida_d;
  logic activo_medicina_q, activo_medicina_d;
  logic muerto_q,          muerto_d;

  // Intermediate next-state terms
  logic [2:0]    estab_sig;
  logic [MW-1:0] muerte_inc;
  logic          muere;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q          <= FELIZ;
      cand_prev_q       <= ESTADO_INV;
      estab_q           <= 3'd0;
      muerte_q          <= '0;
      cambio_q          <= 1'b0;
      activo_comida_q   <= 1'b0;
      activo_medicina_q <= 1'b0;
      muerto_q          <= 1'b0;
    end else begin
      estado_q          <= estado_d;
      cand_prev_q       <= cand_prev_d;
      estab_q           <= estab_d;
      muerte_q          <= muerte_d;
      cambio_q          <= cambio_d;
      activo_comida_q   <= activo_comida_d;
      activo_medicina_q <= activo_medicina_d;
      muerto_q          <= muerto_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_d    = estado_q;
    cand_prev_d = ESTADO_INV;  // outside normal evaluation, forget history
    estab_d     = 3'd0;
    muerte_d    = '0;
    estab_sig   = 3'd0;
    muerte_inc  = muerte_q + MW'(1);
    muere       = 1'b0;

    if (estado_q == ESTADO_INV) begin
      estado_d = FELIZ;
    end else if (estado_q == MUERTO) begin
      estado_d = MUERTO;  // absorbing until reset
    end else if (senal_test) begin
      // Levels and ticks ignored, counters held at 0.
      if (boton_test) estado_d = paso_test(estado_q);
    end else begin
      cand_prev_d = candidato;

      // Death timeout: only ticks advance or clear it.
      muerte_d = muerte_q;
      if (tick_5seg) begin
        if (dos_vacios) begin
          muerte_d = muerte_inc;
          muere    = (muerte_inc == MUERTE_LIM);
        end else begin
          muerte_d = '0;
        end
      end

      // Stability counter value this edge; a candidate seen on N consecutive
      // edges yields N-1 here, so reaching STABLE_LIM means it has persisted
      // STABLE_CYCLES edges.
      if ((candidato == estado_q) || (candidato != cand_prev_q)) estab_sig = 3'd0;
      else                                                       estab_sig = estab_q + 3'd1;

      if (muere) begin
        estado_d = MUERTO;
        muerte_d = '0;
      end else if ((candidato != estado_q) && (estab_sig == STABLE_LIM)) begin
        estado_d = candidato;
      end else begin
        estab_d = estab_sig;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (registered next cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    cambio_d          = (estado_d != estado_q);
    activo_comida_d   = (nivel_energia != NIVEL_LLENO) && (estado_q != MUERTO);
    activo_medicina_d = (estado_q == ENFERMO);
    muerto_d          = muerto_q || (estado_d == MUERTO);
  end

  assign estado          = estado_q;
  assign cambio_estado   = cambio_q;
  assign activo_comida   = activo_comida_q;
  assign activo_medicina = activo_medicina_q;
  assign muerto          = muerto_q;

endmodule

// File: tb/tb_pet_estado_fsm.sv
// -----------------------------------------------------------------------------
// tb_pet_estado_fsm
// Directed scenarios followed by randomized level/tick/test-mode traffic, all
// compared cycle by cycle against a behavioural model of the pet rules.
// -----------------------------------------------------------------------------
module tb_pet_estado_fsm;

  localparam int S  = 4;
  localparam int MT = 6;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0] nivel_animo, nivel_energia, nivel_descanso, nivel_medicina;
  logic tick_5seg, senal_test, boton_test;
  logic [2:0] estado;
  logic cambio_estado, activo_comida, activo_medicina, muerto;

  pet_estado_fsm #(.STABLE_CYCLES(S), .MUERTE_TICKS(MT)) dut (
    .clk             (clk),
    .reset           (reset),
    .nivel_animo     (nivel_animo),
    .nivel_energia   (nivel_energia),
    .nivel_descanso  (nivel_descanso),
    .nivel_medicina  (nivel_medicina),
    .tick_5seg       (tick_5seg),
    .senal_test      (senal_test),
    .boton_test      (boton_test),
    .estado          (estado),
    .cambio_estado   (cambio_estado),
    .activo_comida   (activo_comida),
    .activo_medicina (activo_medicina),
    .muerto          (muerto)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: {estado, cambio, comida, medicina, muerto}
  logic [6:0] exp_q[$];

  // Reference model state
  int m_est, m_streak, m_last_c, m_dcnt;
  bit m_mu, m_cam, m_com, m_med;

  function automatic int ref_cand(int a, int e, int d, int m);
    if (m == 0) return 5;
    if (e == 0) return 2;
    if (d == 0) return 3;
    if (a == 0) return 4;
    if (a >= 2 && e >= 2 && d >= 2 && m >= 2) return 0;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_est = 0; m_streak = 0; m_last_c = -1; m_dcnt = 0;
    m_mu = 0; m_cam = 0; m_com = 0; m_med = 0;
    exp_q.push_back(7'd0);
  endtask

  // One rising edge of the pet rules, using the inputs as sampled.
  task automatic model_edge();
    int c, z, nxt;
    bit dead;
    m_com = (nivel_energia < 2'd3) && (m_est != 6);
    m_med = (m_est == 5);
    nxt = m_est;
    if (m_est != 6) begin
      if (senal_test) begin
        m_streak = 0; m_dcnt = 0;
        if (boton_test) nxt = (m_est + 1) % 6;
      end else begin
        c = ref_cand(nivel_animo, nivel_energia, nivel_descanso, nivel_medicina);
        z = int'(nivel_animo == 0) + int'(nivel_energia == 0) +
            int'(nivel_descanso == 0) + int'(nivel_medicina == 0);
        dead = 0;
        if (tick_5seg) begin
          if (z >= 2) begin m_dcnt++; dead = (m_dcnt >= MT); end
          else m_dcnt = 0;
        end
        if (m_streak > 0 && c == m_last_c) m_streak++;
        else m_streak = 1;
        m_last_c = c;
        if (dead) nxt = 6;
        else if (c != m_est && m_streak >= S) nxt = c;
      end
    end
    m_cam = (nxt != m_est);
    m_est = nxt;
    if (nxt == 6) m_mu = 1;
    exp_q.push_back({3'(m_est), m_cam, m_com, m_med, m_mu});
  endtask

  task automatic check_all(input string tag);
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".estado"},   {5'd0, estado},          {5'd0, e[6:4]});
      chk({tag, ".cambio"},   {7'd0, cambio_estado},   {7'd0, e[3]});
      chk({tag, ".comida"},   {7'd0, activo_comida},   {7'd0, e[2]});
      chk({tag, ".medicina"}, {7'd0, activo_medicina}, {7'd0, e[1]});
      chk({tag, ".muerto"},   {7'd0, muerto},          {7'd0, e[0]});
    end
  endtask

  // Driver: one clock cycle, entered and left at a falling edge.
  task automatic cycle(input string tag, input logic tk, input logic bt);
    tick_5seg = tk; boton_test = bt;
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
    @(negedge clk);
    tick_5seg = 1'b0; boton_test = 1'b0;
  endtask

  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_lv(input logic [1:0] a, input logic [1:0] e,
                        input logic [1:0] d, input logic [1:0] m);
    nivel_animo = a; nivel_energia = e; nivel_descanso = d; nivel_medicina = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] pasos [6];
    int hold, segs;
    pasos[0] = 3'd1; pasos[1] = 3'd2; pasos[2] = 3'd3;
    pasos[3] = 3'd4; pasos[4] = 3'd5; pasos[5] = 3'd0;

    // Reset with full levels
    reset = 1'b1; tick_5seg = 0; senal_test = 0; boton_test = 0;
    set_lv(3, 3, 3, 3);
    #2 model_reset();
    check_all("reset");
    chk("reset_estado", {5'd0, estado}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle("idle", 0, 0);
    chk("idle_comida", {7'd0, activo_comida}, 8'd0);
    chk("idle_estado", {5'd0, estado}, 8'd0);

    // Hunger after exactly S sampled edges
    set_lv(3, 0, 3, 3);
    cycles("hambre_wait", S - 1);
    chk("hambre_early", {5'd0, estado}, 8'd0);
    cycle("hambre", 0, 0);
    chk("hambre_estado", {5'd0, estado}, 8'd2);
    chk("hambre_cambio", {7'd0, cambio_estado}, 8'd1);
    chk("hambre_comida", {7'd0, activo_comida}, 8'd1);
    set_lv(3, 3, 3, 3);
    cycles("feliz_back", S);
    chk("feliz_back_estado", {5'd0, estado}, 8'd0);

    // Short medicina glitch, then a held one
    set_lv(3, 3, 3, 0);
    cycles("glitch", S - 1);
    set_lv(3, 3, 3, 3);
    cycles("glitch_after", S + 1);
    chk("glitch_estado", {5'd0, estado}, 8'd0);
    set_lv(3, 3, 3, 0);
    cycles("enfermo", S + 1);
    chk("enfermo_estado", {5'd0, estado}, 8'd5);
    chk("enfermo_med", {7'd0, activo_medicina}, 8'd1);
    set_lv(3, 3, 3, 3);
    cycles("sano", S + 1);

    // Test-mode stepping
    senal_test = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle("paso", 0, 1);
      chk("paso_estado", {5'd0, estado}, {5'd0, pasos[i]});
      chk("paso_cambio", {7'd0, cambio_estado}, 8'd1);
      cycle("paso_idle", 0, 0);
      chk("paso_idle_cambio", {7'd0, cambio_estado}, 8'd0);
    end
    senal_test = 1'b0;
    set_lv(0, 3, 3, 3);
    cycles("salida_test", S - 1);
    chk("salida_early", {5'd0, estado}, 8'd0);
    cycle("salida_test", 0, 0);
    chk("triste_estado", {5'd0, estado}, 8'd4);

    // Death after MT qualifying ticks
    set_lv(3, 0, 0, 3);
    for (int i = 0; i < MT; i++) begin
      cycle("muerte_tick", 1, 0);
      if (i < MT - 1) cycle("muerte_gap", 0, 0);
    end
    chk("muerte_estado", {5'd0, estado}, 8'd6);
    chk("muerte_flag", {7'd0, muerto}, 8'd1);
    set_lv(3, 3, 3, 3);
    senal_test = 1'b1;
    for (int i = 0; i < 3; i++) cycle("muerto_test", 0, 1);
    chk("muerto_sticky", {5'd0, estado}, 8'd6);
    senal_test = 1'b0;
    do_reset("rst_muerto");

    // Reset mid-hysteresis
    set_lv(3, 0, 3, 3);
    cycles("pre_rst_hist", 3);
    do_reset("rst_hist");
    cycles("post_rst_hist", S - 1);
    chk("post_rst_hist_estado", {5'd0, estado}, 8'd0);
    cycle("post_rst_hist", 0, 0);
    chk("post_rst_hist_cambio", {5'd0, estado}, 8'd2);

    // Reset mid death count
    set_lv(3, 0, 0, 3);
    for (int i = 0; i < 3; i++) cycle("pre_rst_muerte", 1, 0);
    do_reset("rst_muerte");
    for (int i = 0; i < MT - 1; i++) cycle("post_rst_muerte", 1, 0);
    chk("post_rst_vivo", {7'd0, muerto}, 8'd0);
    cycle("post_rst_muerte", 1, 0);
    chk("post_rst_muerto", {5'd0, estado}, 8'd6);
    do_reset("rst_final");

    // Randomized traffic
    for (segs = 0; segs < 250; segs++) begin
      if (m_est == 6 && $urandom_range(0, 3) == 0) do_reset("rnd_reset");
      nivel_animo    = ($urandom_range(0, 9) < 6) ? 2'd3 : 2'($urandom_range(0, 2));
      nivel_energia  = ($urandom_range(0, 9) < 6) ? 2'd3 : 2'($urandom_range(0, 2));
      nivel_descanso = ($urandom_range(0, 9) < 6) ? 2'd3 : 2'($urandom_range(0, 2));
      nivel_medicina = ($urandom_range(0, 9) < 7) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) senal_test = ~senal_test;
      hold = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++)
        cycle("rnd", 1'($urandom_range(0, 3) == 0),
              1'(senal_test && ($urandom_range(0, 2) == 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
